// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control decoder and pipeline control registers.
//   Decodes opcode/funct in ID into a 14-bit control word. The word then moves
//   through the ID/EX, EX/MEM and MEM/WB registers. A multi-cycle multiply
//   holds ID while it runs. Illegal encodings are reported with a pulse and a
//   sticky flag.
//
// Control word: [13]we_reg [12:11]reg_dst [10]alu_src [9]branch [8]we_dm
//               [7:6]dm2reg [5:3]alu_op [2]jump [1]jr [0]mul
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   opcode, funct         instruction fields in ID
//   valid_id              ID holds a real instruction
//   stall_id, flush_id    hazard stall / kill of the ID instruction
//   ctrl_id               combinational decoded word (0 if invalid or illegal)
//   ctrl_ex/mem/wb        pipeline control registers
//   hold_id               freezes PC and IF/ID (stall or multiply busy)
//   mul_busy, mul_done    multiplier busy level / completion pulse
//   illegal               pulse: illegal instruction accepted from ID
//   illegal_sticky        set by illegal, cleared only by reset
//
// state   | meaning
// IDLE    | no multiply in flight
// BUSY    | multiply running, cnt counts down to 0
module ctrl_pipe #(
  parameter int unsigned MUL_LAT = 4,
  parameter bit          EXT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        valid_id,
  input  logic        stall_id,
  input  logic        flush_id,
  output logic [13:0] ctrl_id,
  output logic [13:0] ctrl_ex,
  output logic [13:0] ctrl_mem,
  output logic [13:0] ctrl_wb,
  output logic        hold_id,
  output logic        mul_busy,
  output logic        mul_done,
  output logic        illegal,
  output logic        illegal_sticky
);

  localparam logic [13:0] CW_R    = 14'h2810;
  localparam logic [13:0] CW_LW   = 14'h2440;
  localparam logic [13:0] CW_SW   = 14'h0500;
  localparam logic [13:0] CW_BEQ  = 14'h0208;
  localparam logic [13:0] CW_ADDI = 14'h2400;
  localparam logic [13:0] CW_J    = 14'h0004;
  localparam logic [13:0] CW_JAL  = 14'h3084;
  localparam logic [13:0] CW_ANDI = 14'h2418;
  localparam logic [13:0] CW_ORI  = 14'h2420;
  localparam logic [13:0] CW_SLTI = 14'h2428;
  localparam logic [13:0] CW_JR   = 14'h0002;
  localparam logic [13:0] CW_MUL  = 14'h0011;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} mul_st_e;

  mul_st_e     st_q, st_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        sticky_q, sticky_d;
  logic [13:0] ex_q, ex_d;
  logic [13:0] mem_q, wb_q;

  logic [13:0] dec_word;
  logic        dec_legal;
  logic        accept;

  always_comb begin
    dec_word  = '0;
    dec_legal = 1'b1;
    unique case (opcode)
      6'b000000: begin
        unique case (funct)
          6'b001000: begin
            dec_word  = EXT_EN ? CW_JR : '0;
            dec_legal = EXT_EN;
          end
          6'b011000, 6'b011001: begin
            dec_word  = EXT_EN ? CW_MUL : '0;
            dec_legal = EXT_EN;
          end
          default: dec_word = CW_R;
        endcase
      end
      6'b100011: dec_word = CW_LW;
      6'b101011: dec_word = CW_SW;
      6'b000100: dec_word = CW_BEQ;
      6'b001000: dec_word = CW_ADDI;
      6'b000010: dec_word = CW_J;
      6'b000011: dec_word = CW_JAL;
      6'b001100: begin
        dec_word  = EXT_EN ? CW_ANDI : '0;
        dec_legal = EXT_EN;
      end
      6'b001101: begin
        dec_word  = EXT_EN ? CW_ORI : '0;
        dec_legal = EXT_EN;
      end
      6'b001010: begin
        dec_word  = EXT_EN ? CW_SLTI : '0;
        dec_legal = EXT_EN;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign ctrl_id = valid_id ? dec_word : '0;
  assign hold_id = stall_id | (st_q == ST_BUSY);
  assign accept  = valid_id & ~hold_id & ~flush_id;

  always_comb begin
    ex_d      = accept ? ctrl_id : '0;
    illegal_d = accept & ~dec_legal;
    // sticky rises together with the pulse, not a cycle later
    sticky_d  = sticky_q | illegal_d;
    st_d      = st_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (accept && ctrl_id[0]) begin
          st_d  = ST_BUSY;
          cnt_d = CNT_INIT;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          st_d   = ST_IDLE;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      sticky_q  <= 1'b0;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      sticky_q  <= sticky_d;
      ex_q      <= ex_d;
      // later stages are never stalled so older work drains during a multiply
      mem_q     <= ex_q;
      wb_q      <= mem_q;
    end
  end

  assign ctrl_ex        = ex_q;
  assign ctrl_mem       = mem_q;
  assign ctrl_wb        = wb_q;
  assign mul_busy       = (st_q == ST_BUSY);
  assign mul_done       = done_q;
  assign illegal        = illegal_q;
  assign illegal_sticky = sticky_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        valid_id, stall_id, flush_id;

  logic [13:0] ctrl_id, ctrl_ex, ctrl_mem, ctrl_wb;
  logic        hold_id, mul_busy, mul_done, illegal, illegal_sticky;

  logic [13:0] n_ctrl_id, n_ctrl_ex, n_ctrl_mem, n_ctrl_wb;
  logic        n_hold_id, n_mul_busy, n_mul_done, n_illegal, n_illegal_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.MUL_LAT(4), .EXT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .valid_id(valid_id), .stall_id(stall_id), .flush_id(flush_id),
    .ctrl_id(ctrl_id), .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem), .ctrl_wb(ctrl_wb),
    .hold_id(hold_id), .mul_busy(mul_busy), .mul_done(mul_done),
    .illegal(illegal), .illegal_sticky(illegal_sticky)
  );

  ctrl_pipe #(.MUL_LAT(4), .EXT_EN(1'b0)) dut_noext (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .valid_id(valid_id), .stall_id(stall_id), .flush_id(flush_id),
    .ctrl_id(n_ctrl_id), .ctrl_ex(n_ctrl_ex), .ctrl_mem(n_ctrl_mem), .ctrl_wb(n_ctrl_wb),
    .hold_id(n_hold_id), .mul_busy(n_mul_busy), .mul_done(n_mul_done),
    .illegal(n_illegal), .illegal_sticky(n_illegal_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic v);
    opcode   = op;
    funct    = fn;
    valid_id = v;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [13:0] exp_ext;
    logic [13:0] exp_noext;
  } dec_vec_t;

  dec_vec_t dec_tab[13];

  int busy_cnt;
  int done_seen;

  initial begin
    dec_tab[0]  = '{6'b000000, 6'b100000, 14'h2810, 14'h2810}; // R add
    dec_tab[1]  = '{6'b100011, 6'b000000, 14'h2440, 14'h2440}; // LW
    dec_tab[2]  = '{6'b101011, 6'b000000, 14'h0500, 14'h0500}; // SW
    dec_tab[3]  = '{6'b000100, 6'b000000, 14'h0208, 14'h0208}; // BEQ
    dec_tab[4]  = '{6'b001000, 6'b000000, 14'h2400, 14'h2400}; // ADDI
    dec_tab[5]  = '{6'b000010, 6'b000000, 14'h0004, 14'h0004}; // J
    dec_tab[6]  = '{6'b000011, 6'b000000, 14'h3084, 14'h3084}; // JAL
    dec_tab[7]  = '{6'b001100, 6'b000000, 14'h2418, 14'h0000}; // ANDI
    dec_tab[8]  = '{6'b001101, 6'b000000, 14'h2420, 14'h0000}; // ORI
    dec_tab[9]  = '{6'b001010, 6'b000000, 14'h2428, 14'h0000}; // SLTI
    dec_tab[10] = '{6'b000000, 6'b001000, 14'h0002, 14'h0000}; // JR
    dec_tab[11] = '{6'b000000, 6'b011001, 14'h0011, 14'h0000}; // MULTU
    dec_tab[12] = '{6'b111111, 6'b000000, 14'h0000, 14'h0000}; // undefined

    rst_n = 1'b0; stall_id = 1'b0; flush_id = 1'b0;
    drive(6'b0, 6'b0, 1'b0);
    tick(); tick();
    chk("rst_ex", 32'(ctrl_ex), 0);
    chk("rst_wb", 32'(ctrl_wb), 0);
    chk("rst_busy", 32'(mul_busy), 0);
    chk("rst_sticky", 32'(illegal_sticky), 0);
    stall_id = 1'b1; #1;
    chk("rst_hold_eq_stall", 32'(hold_id), 1);

    // decode table, held so nothing is accepted
    valid_id = 1'b1;
    foreach (dec_tab[i]) begin
      opcode = dec_tab[i].op; funct = dec_tab[i].fn; #1;
      chk($sformatf("dec_ext_%0d", i), 32'(ctrl_id), 32'(dec_tab[i].exp_ext));
      chk($sformatf("dec_noext_%0d", i), 32'(n_ctrl_id), 32'(dec_tab[i].exp_noext));
    end
    valid_id = 1'b0; #1;
    chk("invalid_ctrl_id", 32'(ctrl_id), 0);
    stall_id = 1'b0;
    rst_n = 1'b1;
    tick();

    // 1: LW flows through the pipe
    drive(6'b100011, 6'b0, 1'b1);
    tick();
    valid_id = 1'b0;
    chk("lw_ex", 32'(ctrl_ex), 32'h2440);
    tick();
    chk("lw_mem", 32'(ctrl_mem), 32'h2440);
    chk("lw_ex_bubble", 32'(ctrl_ex), 0);
    tick();
    chk("lw_wb", 32'(ctrl_wb), 32'h2440);

    // 2: ADDI held two cycles by stall
    drive(6'b001000, 6'b0, 1'b1);
    stall_id = 1'b1; #1;
    chk("stall_hold", 32'(hold_id), 1);
    tick();
    chk("stall_ex_1", 32'(ctrl_ex), 0);
    tick();
    chk("stall_ex_2", 32'(ctrl_ex), 0);
    stall_id = 1'b0; #1;
    chk("stall_hold_rel", 32'(hold_id), 0);
    tick();
    valid_id = 1'b0;
    chk("addi_ex", 32'(ctrl_ex), 32'h2400);

    // 3: MULT with ORI waiting behind it
    drive(6'b000000, 6'b011000, 1'b1);
    tick();
    drive(6'b001101, 6'b0, 1'b1);
    chk("mul_busy_1", 32'(mul_busy), 1);
    chk("mul_ex_1", 32'(ctrl_ex), 32'h0011);
    chk("mul_hold_1", 32'(hold_id), 1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk($sformatf("mul_busy_%0d", k), 32'(mul_busy), 1);
      chk($sformatf("mul_ex_%0d", k), 32'(ctrl_ex), 0);
      chk($sformatf("mul_done_%0d", k), 32'(mul_done), 0);
    end
    tick();
    chk("mul_busy_5", 32'(mul_busy), 0);
    chk("mul_done_5", 32'(mul_done), 1);
    chk("mul_ex_5", 32'(ctrl_ex), 0);
    chk("mul_hold_5", 32'(hold_id), 0);
    tick();
    valid_id = 1'b0;
    chk("ori_ex_6", 32'(ctrl_ex), 32'h2420);
    chk("mul_done_6", 32'(mul_done), 0);
    chk("sticky_pre", 32'(illegal_sticky), 0);

    // 4: illegal opcode, then ANDI on the EXT_EN=0 instance
    drive(6'b111111, 6'b0, 1'b1);
    tick();
    valid_id = 1'b0;
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_sticky", 32'(illegal_sticky), 1);
    chk("ill_ex", 32'(ctrl_ex), 0);
    tick();
    chk("ill_pulse_end", 32'(illegal), 0);
    chk("ill_sticky_hold", 32'(illegal_sticky), 1);
    drive(6'b001100, 6'b0, 1'b1);
    tick();
    valid_id = 1'b0;
    chk("noext_andi_ill", 32'(n_illegal), 1);
    chk("noext_andi_sticky", 32'(n_illegal_sticky), 1);
    chk("noext_andi_ex", 32'(n_ctrl_ex), 0);
    chk("ext_andi_ill", 32'(illegal), 0);
    chk("ext_andi_ex", 32'(ctrl_ex), 32'h2418);

    // 5: JAL flushed, then JAL accepted
    drive(6'b000011, 6'b0, 1'b1);
    flush_id = 1'b1;
    tick();
    flush_id = 1'b0;
    chk("jal_flush_ex", 32'(ctrl_ex), 0);
    tick();
    valid_id = 1'b0;
    chk("jal_ex", 32'(ctrl_ex), 32'h3084);

    // stall and flush together
    drive(6'b001000, 6'b0, 1'b1);
    stall_id = 1'b1; flush_id = 1'b1; #1;
    chk("sf_hold", 32'(hold_id), 1);
    tick();
    chk("sf_ex", 32'(ctrl_ex), 0);
    stall_id = 1'b0; flush_id = 1'b0; valid_id = 1'b0;

    // 6: MULT, flush during busy, reset at busy cycle 2
    drive(6'b000000, 6'b011000, 1'b1);
    tick();
    drive(6'b001000, 6'b0, 1'b1);
    flush_id = 1'b1;
    tick();
    flush_id = 1'b0; valid_id = 1'b0;
    chk("flush_busy_ex", 32'(ctrl_ex), 0);
    chk("flush_busy_keep", 32'(mul_busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", 32'(mul_busy), 0);
    chk("mrst_done", 32'(mul_done), 0);
    chk("mrst_ex", 32'(ctrl_ex), 0);
    chk("mrst_mem", 32'(ctrl_mem), 0);
    chk("mrst_wb", 32'(ctrl_wb), 0);
    chk("mrst_ill", 32'(illegal), 0);
    chk("mrst_sticky", 32'(illegal_sticky), 0);
    chk("mrst_hold", 32'(hold_id), 0);

    drive(6'b000000, 6'b011000, 1'b1);
    tick();
    valid_id = 1'b0;
    busy_cnt = 0; done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (mul_busy) busy_cnt++;
      if (mul_done) done_seen++;
      tick();
    end
    chk("remul_busy_len", 32'(busy_cnt), 4);
    chk("remul_done_cnt", 32'(done_seen), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
